button_debounce_reader: RTL and testbench
=========================================

Name: button_debounce_reader

Overview:
- Input-side counterpart to the board LED driver: samples a raw push-button pin on the 50 MHz board clock (20 ns period).
- Synchronises and debounces the pin.
- Emits clean level and single-cycle event pulses: press, release, long-press.
- Keeps a toggle state that LED logic can display directly.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronised input must stay stable before a change is accepted (20 ms at 50 MHz); legal range >= 2.
- LONG_PRESS_CYCLES, 50_000_000, cycles after the accepted press at which LONG_PULSE fires (1 s); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous active-high reset
- BTN  input  1  raw asynchronous button pin
- PRESSED  output  1  debounced pressed level
- PRESS_PULSE  output  1  one-cycle pulse on accepted press
- RELEASE_PULSE  output  1  one-cycle pulse on accepted release
- LONG_PULSE  output  1  one-cycle pulse when a press reaches LONG_PRESS_CYCLES
- TOGGLE  output  1  inverts on every accepted press

Behaviour:
- Reset: RST sampled high at a rising edge forces all outputs to 0, the FSM to IDLE, both counters to 0 and both synchroniser flops to the released level. RST asserted mid-press discards the press with no pulses. After reset release, a button still held is treated as a new press and fully debounced.
- Input path: BTN is polarity-normalised (inverted when ACTIVE_LOW=1) into a 2-flop synchroniser giving s (1 = pressed). Only s is used downstream.
- Counters:
  - deb_cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - long_cnt, width $clog2(LONG_PRESS_CYCLES+1).
  - Both saturate and never wrap.
- FSM states and transitions:
  - IDLE: s=1 -> PRESS_WAIT with deb_cnt=1.
  - PRESS_WAIT:
    - s=0 -> IDLE, deb_cnt=0 (bounce rejected, no output).
    - s=1 and deb_cnt=DEBOUNCE_CYCLES-1 -> PRESSED.
    - Otherwise deb_cnt++.
  - PRESSED:
    - long_cnt++ each cycle.
    - long_cnt reaching LONG_PRESS_CYCLES-1 with s=1 -> LONG_HELD.
    - s=0 -> RELEASE_WAIT with deb_cnt=1.
  - LONG_HELD: holds, long_cnt frozen. s=0 -> RELEASE_WAIT with deb_cnt=1.
  - RELEASE_WAIT:
    - s=1 -> back to LONG_HELD if the long flag is set, else PRESSED; long_cnt resumes from its held value and no pulse is emitted.
    - s=0 and deb_cnt=DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise deb_cnt++.
- Outputs, all registered:
  - PRESSED=1 in PRESSED, LONG_HELD and RELEASE_WAIT; otherwise 0.
  - PRESS_PULSE=1 for exactly one cycle on the PRESS_WAIT->PRESSED transition. TOGGLE inverts on the same edge.
  - LONG_PULSE=1 for exactly one cycle on the PRESSED->LONG_HELD transition; at most once per press.
  - RELEASE_PULSE=1 for exactly one cycle on the RELEASE_WAIT->IDLE transition. PRESSED falls on the same edge.
  - long_cnt and the long flag clear on entry to IDLE.
- Latency:
  - PRESS_PULSE is high in the cycle beginning 2+DEBOUNCE_CYCLES rising edges after the first edge that samples BTN stably pressed.
  - Release latency is identical.
  - LONG_PULSE fires LONG_PRESS_CYCLES edges after PRESS_PULSE, provided no release was accepted in between.
- Simultaneous events: a release accepted in the same cycle the long threshold is reached gives priority to the release; no LONG_PULSE is emitted. PRESS_PULSE and RELEASE_PULSE can never be high together.

Decomposition:
- Package btn_pkg: FSM state enum (IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT) and the default timing constants derived from CLK_HZ=50_000_000.
- One natural sub-module: sync_2ff, a 2-flop synchroniser with a parameterised reset value. It is reusable for other board inputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1 and a 20 ns clock.

1. Clean press: BTN 1->0 held 40 cycles.
   - PRESS_PULSE high exactly at edge 6 after the first low sample.
   - TOGGLE 0->1.
   - LONG_PULSE at edge 26.
   - PRESSED stays 1.
2. Bounce rejection: BTN toggles 0/1 every 2 cycles for 30 cycles, then rests at 1.
   - No pulses; PRESSED and TOGGLE remain 0.
3. Short press and release: BTN low 10 cycles, then high.
   - One PRESS_PULSE.
   - RELEASE_PULSE 6 edges after the first high sample.
   - No LONG_PULSE.
   - PRESSED back to 0.
4. Release bounce inside a long hold: after LONG_PULSE, BTN high for 2 cycles then low again.
   - No RELEASE_PULSE and no second LONG_PULSE.
   - PRESSED stays 1.
5. Reset mid-press: RST pulsed 1 cycle while in PRESSED with BTN still low.
   - All outputs 0 on the next cycle.
   - A fresh PRESS_PULSE follows 6 edges after reset deasserts.
   - TOGGLE goes 0->1.
6. Two full presses: TOGGLE goes 0->1->0, with exactly two PRESS_PULSEs and two RELEASE_PULSEs, in strict alternation.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and board timing defaults for the push-button reader.
// Default timings assume the 50 MHz board clock.
package btn_pkg;

  localparam int unsigned CLK_HZ                = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = CLK_HZ / 50;  // 20 ms
  localparam int unsigned DEF_LONG_PRESS_CYCLES = CLK_HZ;       // 1 s

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_LONG_HELD    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous board input.
// The reset value is a parameter so each input can start in its inactive level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/button_debounce_reader.sv
// Debounces a raw push-button pin and produces a clean level, press/release/long-press
// pulses and a press-toggled state, all from registered outputs.
module button_debounce_reader
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE,
  output logic TOGGLE
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LONG_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_PRESS_CYCLES);

  logic btn_norm_s;
  logic btn_s;

  btn_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d, deb_inc_s;
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d, long_inc_s;
  logic              long_flag_q, long_flag_d;
  logic              press_ev_q, press_ev_d;
  logic              rel_ev_q, rel_ev_d;
  logic              long_ev_q, long_ev_d;

  logic pressed_q, pressed_d;
  logic press_pulse_q, press_pulse_d;
  logic rel_pulse_q, rel_pulse_d;
  logic long_pulse_q, long_pulse_d;
  logic toggle_q, toggle_d;

  // Normalise polarity first so the synchroniser resets to "released" (0).
  assign btn_norm_s = BTN ^ ACTIVE_LOW;

  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (btn_norm_s),
    .q_o  (btn_s)
  );

  assign deb_inc_s  = (deb_cnt_q == DEB_MAX)   ? deb_cnt_q  : deb_cnt_q + DEB_W'(1);
  assign long_inc_s = (long_cnt_q == LONG_MAX) ? long_cnt_q : long_cnt_q + LONG_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      long_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      press_ev_q  <= 1'b0;
      rel_ev_q    <= 1'b0;
      long_ev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      long_cnt_q  <= long_cnt_d;
      long_flag_q <= long_flag_d;
      press_ev_q  <= press_ev_d;
      rel_ev_q    <= rel_ev_d;
      long_ev_q   <= long_ev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    long_cnt_d  = long_cnt_q;
    long_flag_d = long_flag_q;
    press_ev_d  = 1'b0;
    rel_ev_d    = 1'b0;
    long_ev_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d   = ST_PRESS_WAIT;
          deb_cnt_d = DEB_W'(1);
        end else begin
          deb_cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = ST_PRESSED;
          deb_cnt_d  = '0;
          press_ev_d = 1'b1;
        end else begin
          deb_cnt_d = deb_inc_s;
        end
      end
      ST_PRESSED: begin
        // Release wins over a long threshold reached in the same cycle.
        if (!btn_s) begin
          state_d   = ST_RELEASE_WAIT;
          deb_cnt_d = DEB_W'(1);
        end else if (long_cnt_q == LONG_LAST) begin
          state_d     = ST_LONG_HELD;
          long_flag_d = 1'b1;
          long_ev_d   = 1'b1;
        end else begin
          long_cnt_d = long_inc_s;
        end
      end
      ST_LONG_HELD: begin
        if (!btn_s) begin
          state_d   = ST_RELEASE_WAIT;
          deb_cnt_d = DEB_W'(1);
        end else begin
          state_d = ST_LONG_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d   = long_flag_q ? ST_LONG_HELD : ST_PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = ST_IDLE;
          deb_cnt_d   = '0;
          long_cnt_d  = '0;
          long_flag_d = 1'b0;
          rel_ev_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_inc_s;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        deb_cnt_d   = '0;
        long_cnt_d  = '0;
        long_flag_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pressed_d     = (state_q == ST_PRESSED) || (state_q == ST_LONG_HELD) ||
                    (state_q == ST_RELEASE_WAIT);
    press_pulse_d = press_ev_q;
    rel_pulse_d   = rel_ev_q;
    long_pulse_d  = long_ev_q;
    toggle_d      = toggle_q ^ press_ev_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pressed_q     <= 1'b0;
      press_pulse_q <= 1'b0;
      rel_pulse_q   <= 1'b0;
      long_pulse_q  <= 1'b0;
      toggle_q      <= 1'b0;
    end else begin
      pressed_q     <= pressed_d;
      press_pulse_q <= press_pulse_d;
      rel_pulse_q   <= rel_pulse_d;
      long_pulse_q  <= long_pulse_d;
      toggle_q      <= toggle_d;
    end
  end

  assign PRESSED       = pressed_q;
  assign PRESS_PULSE   = press_pulse_q;
  assign RELEASE_PULSE = rel_pulse_q;
  assign LONG_PULSE    = long_pulse_q;
  assign TOGGLE        = toggle_q;

endmodule : button_debounce_reader

// File: tb/tb_button_debounce_reader.sv
// Cycle-accurate vector bench for button_debounce_reader (DEBOUNCE=4, LONG=20, active-low pin).
// Pulse positions come from the stated latencies; levels are derived from the pulses.
module tb_button_debounce_reader;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;
  localparam int          LAT = 2 + DEB;  // sampled edge -> pulse visible
  localparam int          MAXV = 512;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic pressed_o, press_o, rel_o, long_o, toggle_o;

  always #10 clk = ~clk;

  button_debounce_reader #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LNG),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .BTN          (btn),
    .PRESSED      (pressed_o),
    .PRESS_PULSE  (press_o),
    .RELEASE_PULSE(rel_o),
    .LONG_PULSE   (long_o),
    .TOGGLE       (toggle_o)
  );

  typedef struct {
    logic  rst;
    logic  btn;
    logic  pressed;
    logic  press;
    logic  rel;
    logic  lng;
    logic  toggle;
    string tag;
  } vec_t;

  vec_t vecs[MAXV];
  int   nv = 0;
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input string tag, input logic r, input logic b, input int n);
    for (int k = 0; k < n; k++) begin
      vecs[nv].rst     = r;
      vecs[nv].btn     = b;
      vecs[nv].pressed = 1'b0;
      vecs[nv].press   = 1'b0;
      vecs[nv].rel     = 1'b0;
      vecs[nv].lng     = 1'b0;
      vecs[nv].toggle  = 1'b0;
      vecs[nv].tag     = tag;
      nv++;
    end
  endtask

  initial begin
    int   base;
    logic lvl_p, lvl_t;
    vec_t e;
    logic [4:0] got, want;

    rst = 1'b1;
    btn = 1'b1;

    add("reset", 1'b1, 1'b1, 3);

    base = nv; add("clean_press", 1'b0, 1'b0, 40);
    vecs[base + LAT].press = 1'b1;
    vecs[base + LAT + LNG].lng = 1'b1;
    base = nv; add("clean_release", 1'b0, 1'b1, 12);
    vecs[base + LAT].rel = 1'b1;

    for (int j = 0; j < 15; j++) add("bounce", 1'b0, ((j % 2) == 1), 2);
    add("bounce_rest", 1'b0, 1'b1, 10);

    base = nv; add("short_press", 1'b0, 1'b0, 10);
    vecs[base + LAT].press = 1'b1;
    base = nv; add("short_release", 1'b0, 1'b1, 12);
    vecs[base + LAT].rel = 1'b1;

    base = nv; add("long_hold", 1'b0, 1'b0, 30);
    vecs[base + LAT].press = 1'b1;
    vecs[base + LAT + LNG].lng = 1'b1;
    add("rel_bounce_hi", 1'b0, 1'b1, 2);
    add("rel_bounce_lo", 1'b0, 1'b0, 20);
    base = nv; add("long_release", 1'b0, 1'b1, 12);
    vecs[base + LAT].rel = 1'b1;

    base = nv; add("pre_reset_press", 1'b0, 1'b0, 10);
    vecs[base + LAT].press = 1'b1;
    add("mid_reset", 1'b1, 1'b0, 1);
    base = nv; add("post_reset_press", 1'b0, 1'b0, 12);
    vecs[base + LAT].press = 1'b1;
    base = nv; add("post_reset_release", 1'b0, 1'b1, 12);
    vecs[base + LAT].rel = 1'b1;

    add("reset2", 1'b1, 1'b1, 2);
    for (int j = 0; j < 2; j++) begin
      base = nv; add("dual_press", 1'b0, 1'b0, 10);
      vecs[base + LAT].press = 1'b1;
      base = nv; add("dual_release", 1'b0, 1'b1, 12);
      vecs[base + LAT].rel = 1'b1;
    end

    // Levels: reset clears both; a press pulse raises PRESSED and flips TOGGLE;
    // a release pulse drops PRESSED on the same cycle.
    lvl_p = 1'b0;
    lvl_t = 1'b0;
    for (int i = 0; i < nv; i++) begin
      if (vecs[i].rst) begin
        lvl_p = 1'b0;
        lvl_t = 1'b0;
      end else if (vecs[i].press) begin
        lvl_p = 1'b1;
        lvl_t = ~lvl_t;
      end else if (vecs[i].rel) begin
        lvl_p = 1'b0;
      end
      vecs[i].pressed = lvl_p;
      vecs[i].toggle  = lvl_t;
    end

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      btn = vecs[i].btn;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      n_vec++;
      got = {pressed_o, press_o, rel_o, long_o, toggle_o};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL vec %0d scoreboard: no expected entry, got pressed/press/rel/long/toggle=%b", i, got);
      end else begin
        e    = exp_q.pop_front();
        want = {e.pressed, e.press, e.rel, e.lng, e.toggle};
        if (got !== want) begin
          n_err++;
          $display("FAIL vec %0d %s: pressed/press/rel/long/toggle got %b expected %b",
                   i, e.tag, got, want);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_button_debounce_reader
